regfile_access_ctrl: RTL

- Initiator-side controller that drives the read/write port set of `register_file`.
- Accepts single-beat requests on a valid/ready channel and returns read data on a valid/ready response channel.
- After reset, zero-initialises every entry before accepting traffic.
- Sits between a client (decoder, debug port, or bench) and one `register_file` instance.

---
 rtl/regfile_access_pkg.sv | 25 ++
 rtl/register_file.sv | 30 +++
 rtl/regfile_access_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/regfile_access_pkg.sv
// Shared types and constants for the register-file access controller.
package regfile_access_pkg;

    // Controller states; INIT is the reset state and is never re-entered
    // without a reset.
    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_N     = 4;

    // Zero-fill sweeps every entry once, one entry per cycle.
    localparam int unsigned DEFAULT_INIT_CYCLES = DEFAULT_N;

    // Number of zero-fill cycles needed for a file of n entries.
    function automatic int unsigned init_cycles(input int unsigned n);
        return n;
    endfunction

endpackage

// File: rtl/register_file.sv
// Simple synchronous register file: write commits on the clock edge,
// read data is registered and holds while read_en is low.
module register_file #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int AW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             read_en,
    input  logic [AW-1:0]    read_addr,
    input  logic             write_en,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] mem [N];

    // Storage and registered read port; contents are not reset, the
    // controller zero-fills them after every reset.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= data_in;
        end
        if (read_en) begin
            data_out <= mem[read_addr];
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for register_file: zero-fills the file after
// reset, then serves single-beat read/write requests, returning read data
// on a valid/ready response channel.
module regfile_access_ctrl
    import regfile_access_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int AW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             init_done,
    output logic             rf_read_en,
    output logic [AW-1:0]    rf_read_addr,
    output logic             rf_write_en,
    output logic [AW-1:0]    rf_write_addr,
    output logic [WIDTH-1:0] rf_data_in,
    input  logic [WIDTH-1:0] rf_data_out
);

    localparam logic [AW-1:0] INIT_LAST = AW'(init_cycles(N) - 1);

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     init_cnt;
    logic [AW-1:0]     cap_addr;
    logic [WIDTH-1:0]  cap_wdata;

    // State register, zero-fill counter and request capture; reset restarts
    // the fill from entry 0 and drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                init_cnt <= init_cnt + AW'(1);
            end
            if (state == IDLE && req_valid) begin
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
        end
    end

    // Next-state and output decode; outputs depend only on state and the
    // captured fields, except rsp_rdata which passes the file's held data.
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        init_done     = 1'b1;
        rf_read_en    = 1'b0;
        rf_read_addr  = '0;
        rf_write_en   = 1'b0;
        rf_write_addr = '0;
        rf_data_in    = '0;
        case (state)
            INIT: begin
                init_done     = 1'b0;
                rf_write_en   = 1'b1;
                rf_write_addr = init_cnt;
                rf_data_in    = '0;
                if (init_cnt == INIT_LAST) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                rf_write_en   = 1'b1;
                rf_write_addr = cap_addr;
                rf_data_in    = cap_wdata;
                state_next    = IDLE;
            end
            READ: begin
                rf_read_en   = 1'b1;
                rf_read_addr = cap_addr;
                state_next   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rf_data_out;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

endmodule
